w0rm_alu_writeback: RTL
=======================

Name: w0rm_alu_writeback

Overview:
- Consumer end of the ALU result interface.
- Accepts completed ALU results (value, destination register, write enable, flags) and buffers them in a small skid FIFO.
- Drives the ALU's `mem_ready` backpressure and arbitrates one register-file write port between ALU results and memory-load returns.
- Maintains the architectural flags register and a per-register pending-write bitmap for the issue stage's hazard checks.

Parameters:
- DATA_WIDTH, 8, width of result/load data and register-file write data.
- REG_ADDR_WIDTH, 4, register index width (2^REG_ADDR_WIDTH registers).
- FIFO_DEPTH, 2, ALU result buffer entries; power of two, 2..8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered ALU results.
- alu_result  in  DATA_WIDTH  ALU result value.
- alu_result_valid  in  1  ALU result present.
- alu_dest_reg  in  REG_ADDR_WIDTH  destination register of the result.
- alu_write_en  in  1  result updates the register file (0 = flags-only op).
- alu_flags  in  4  {carry, overflow, negative, zero}, already masked by the ALU.
- alu_mem_ready  out  1  to ALU `mem_ready`; high = result accepted this edge.
- load_valid  in  1  memory-load write request.
- load_data  in  DATA_WIDTH  load value.
- load_dest_reg  in  REG_ADDR_WIDTH  load destination.
- load_ready  out  1  load accepted this edge.
- rf_we  out  1  register-file write strobe (registered).
- rf_addr  out  REG_ADDR_WIDTH  write address (registered).
- rf_wdata  out  DATA_WIDTH  write data (registered).
- flags  out  4  architectural flags (registered).
- reg_pending  out  2^REG_ADDR_WIDTH  bit i set while a buffered write to register i is outstanding.

Behaviour:
- Reset (rst_n low, async): FIFO empty; rf_we=0, rf_addr=0, rf_wdata=0, flags=0, reg_pending=0. Combinational outputs then evaluate to alu_mem_ready=1 and load_ready=1.
- ALU handshake:
  - alu_mem_ready = (count != FIFO_DEPTH), decoded from the registered count only; no combinational path from any input.
  - Transfer occurs on an edge where alu_result_valid && alu_mem_ready. That push writes {result, dest, write_en, flags} at the tail.
  - When alu_mem_ready is low, the ALU holds its result. The block must not sample it.
- Load handshake: load_ready = 1 always. A load has absolute priority for the write port.
- Drain, each edge:
  - If load_valid: rf_we=1, rf_addr=load_dest_reg, rf_wdata=load_data. FIFO head is not popped.
  - Else if FIFO non-empty: pop the head. flags <= head.flags. rf_we=head.write_en, rf_addr=head.dest, rf_wdata=head.result.
  - Else rf_we=0. rf_addr and rf_wdata hold their values.
- Latency (no bypass): result accepted at edge N is written at edge N+1 (rf_we visible during cycle N+1), provided there is no load and it reaches the head. Flags update on the same edge as its rf write.
- Push and pop on the same edge: count unchanged. When full, alu_mem_ready stays low that cycle even if a pop occurs (conservative).
- Pointers wrap modulo FIFO_DEPTH. count is FIFO_DEPTH+1 states wide.
- reg_pending is the OR, over valid FIFO entries with write_en=1, of onehot(dest). It is combinational from registered FIFO state. An entry leaves pending on the edge it is popped.
- Flush (synchronous, high at edge):
  - Empties the FIFO and clears reg_pending.
  - Any simultaneous push is dropped. flags are not changed.
  - A simultaneous load still writes.
  - rf_we from an ALU pop is suppressed that edge.
- Reset mid-operation: all buffered results are lost. rf_we drops immediately (async).
- Register 0 is not special: writes to index 0 are performed.

Optional Feature:
- Macro: W0RM_WB_BYPASS_EN.
- Defined: when FIFO is empty, load_valid=0, flush=0 and an ALU transfer occurs at edge N, the result is written to rf_*/flags at edge N itself. No FIFO entry is created, reg_pending never shows it, and latency is 0 cycles after acceptance.
- Undefined: every accepted result passes through the FIFO (minimum latency 1). The bypass logic is absent.

Test Plan:
- Single result: alu_result=0x5A, dest=3, write_en=1, flags=4'b0001, one-cycle valid.
  - Next edge: rf_we=1, rf_addr=3, rf_wdata=0x5A, flags=4'b0001.
  - reg_pending[3]=1 for exactly one cycle.
  - With W0RM_WB_BYPASS_EN: write on the acceptance edge, reg_pending stays 0.
- Backpressure: hold load_valid=1 while streaming 3 ALU results 0x11, 0x22, 0x33.
  - alu_mem_ready drops after 2 accepts; 0x33 is held.
  - Release load: writes occur in order 0x11, 0x22, 0x33, with no loss or duplication.
- Collision: load_valid=1 (0x77 → r5) on the same cycle as FIFO head (0x10 → r2).
  - r5 written first, r2 on the following edge.
  - flags change only with the r2 write.
- Flags-only op: write_en=0, flags=4'b1000.
  - rf_we stays 0, flags becomes 4'b1000, reg_pending stays 0.
- Flush with 2 buffered entries and a simultaneous ALU push:
  - No ALU rf writes follow, reg_pending → 0, flags unchanged.
  - alu_mem_ready=1 next cycle.
- Async reset asserted mid-stream (FIFO holding 2 entries):
  - Outputs go to reset values immediately with no clock edge.
  - After release, no stale writes occur.

Source files
------------

// File: rtl/w0rm_alu_writeback.sv
// ALU result writeback: skid FIFO into one register-file write port shared with loads. Optional W0RM_WB_BYPASS_EN.
// Latency: 1 edge from acceptance to rf write (0 with bypass when idle); loads always take the port first.
// Backpressure: alu_mem_ready decodes the registered count only; loads are never stalled.
module w0rm_alu_writeback #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_result_valid,
    input  logic [REG_ADDR_WIDTH-1:0]     alu_dest_reg,
    input  logic                          alu_write_en,
    input  logic [3:0]                    alu_flags,
    output logic                          alu_mem_ready,
    input  logic                          load_valid,
    input  logic [DATA_WIDTH-1:0]         load_data,
    input  logic [REG_ADDR_WIDTH-1:0]     load_dest_reg,
    output logic                          load_ready,
    output logic                          rf_we,
    output logic [REG_ADDR_WIDTH-1:0]     rf_addr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    output logic [3:0]                    flags,
    output logic [(1<<REG_ADDR_WIDTH)-1:0] reg_pending
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int NREG  = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     q_result [FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] q_dest   [FIFO_DEPTH];
    logic                      q_we     [FIFO_DEPTH];
    logic [3:0]                q_flags  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             accept;
    logic             bypass_take;
    logic             push;
    logic             pop;

    assign empty         = (count == '0);
    assign alu_mem_ready = (count != CNT_W'(FIFO_DEPTH));
    assign load_ready    = 1'b1;
    assign accept        = alu_result_valid && alu_mem_ready;

`ifdef W0RM_WB_BYPASS_EN
    // An idle port lets a fresh result skip the buffer entirely.
    assign bypass_take = accept && empty && !load_valid && !flush;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = accept && !flush && !bypass_take;
    assign pop  = !load_valid && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_result[wr_ptr] <= alu_result;
            q_dest[wr_ptr]   <= alu_dest_reg;
            q_we[wr_ptr]     <= alu_write_en;
            q_flags[wr_ptr]  <= alu_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            flags    <= '0;
        end else if (load_valid) begin
            rf_we    <= 1'b1;
            rf_addr  <= load_dest_reg;
            rf_wdata <= load_data;
        end else if (flush) begin
            // The head is discarded, not written, and flags keep their value.
            rf_we <= 1'b0;
        end else if (!empty) begin
            rf_we    <= q_we[rd_ptr];
            rf_addr  <= q_dest[rd_ptr];
            rf_wdata <= q_result[rd_ptr];
            flags    <= q_flags[rd_ptr];
        end else if (bypass_take) begin
            rf_we    <= alu_write_en;
            rf_addr  <= alu_dest_reg;
            rf_wdata <= alu_result;
            flags    <= alu_flags;
        end else begin
            rf_we <= 1'b0;
        end
    end

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        reg_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && q_we[idx]) begin
                reg_pending[q_dest[idx]] = 1'b1;
            end
        end
    end

    logic unused_nreg;
    assign unused_nreg = (NREG == 0);
endmodule
